// File: rtl/kamus_pkg.sv
// Shared types and constants for the Kamus load/store unit: operation and
// FSM encodings, byte-enable patterns and small op-classification helpers.
package kamus_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic op_is_store(input lsu_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] op_size(input lsu_op_t op);
        logic [1:0] size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
            default:              size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic op_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
        logic mis;
        case (op_size(op))
            SIZE_HALF: mis = addr_lo[0];
            SIZE_WORD: mis = |addr_lo;
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Combinational lane placement for stores and lane selection plus sign/zero
// extension for loads; low address bits are forced to natural alignment.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [1:0]  size;
    logic [1:0]  off;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        size = op_size(op);
        // Misaligned offsets fold down to the containing halfword/word.
        case (size)
            SIZE_HALF: off = {addr_lo[1], 1'b0};
            SIZE_WORD: off = 2'b00;
            default:   off = addr_lo;
        endcase
        rbyte = rdata[{off, 3'b000} +: 8];
        rhalf = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be         = BE_NONE;
        wdata_lane = '0;
        case (size)
            SIZE_BYTE: begin
                be         = BE_BYTE << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                be         = off[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = BE_WORD;
                wdata_lane = wdata;
            end
        endcase
    end

    always_comb begin
        rdata_ext = '0;
        case (op)
            OP_LB:   rdata_ext = {{24{rbyte[7]}}, rbyte};
            OP_LBU:  rdata_ext = {24'd0, rbyte};
            OP_LH:   rdata_ext = {{16{rhalf[15]}}, rhalf};
            OP_LHU:  rdata_ext = {16'd0, rhalf};
            OP_LW:   rdata_ext = rdata;
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/kamus_lsu.sv
// RV32 load/store unit: IDLE/REQ/WAIT/DONE handshake toward data memory.
// Define KAMUS_LSU_MISALIGN_TRAP_EN to complete misaligned ops with an error.
module kamus_lsu
    import kamus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  lsu_op_t     req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    lsu_state_t  state;
    lsu_state_t  state_next;
    lsu_op_t     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        trap;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;

    assign accept = (state == ST_IDLE) && req_valid_i;

`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
    assign trap = op_misaligned(req_op_i, req_addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    kamus_lsu_align u_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (dmem_rdata_i),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (req_valid_i) state_next = trap ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem_gnt_i) state_next = op_is_store(op_q) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (dmem_rvalid_i) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Response data is only rewritten on the way into DONE, so it holds between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= OP_LB;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                err_q   <= trap;
                if (trap) rdata_q <= '0;
            end
            if ((state == ST_REQ) && dmem_gnt_i && op_is_store(op_q)) rdata_q <= '0;
            if ((state == ST_WAIT) && dmem_rvalid_i) rdata_q <= rdata_ext;
        end
    end

    always_comb begin
        req_ready_o  = (state == ST_IDLE);
        stall_o      = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_err_o    = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = BE_NONE;
        dmem_wdata_o = '0;
        case (state)
            ST_IDLE: stall_o = req_valid_i && !rst_i;
            ST_REQ: begin
                stall_o      = 1'b1;
                dmem_req_o   = 1'b1;
                dmem_we_o    = op_is_store(op_q);
                dmem_addr_o  = {addr_q[31:2], 2'b00};
                dmem_be_o    = be;
                dmem_wdata_o = wdata_lane;
            end
            ST_WAIT: stall_o = 1'b1;
            default: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
            end
        endcase
    end

    assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_kamus_lsu.sv
// Self-checking bench for kamus_lsu: directed scenarios plus random ops
// compared against a byte-arithmetic reference model.
module tb_kamus_lsu;
    import kamus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    lsu_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rdata = 32'd0;

    always #5 clk = ~clk;

    kamus_lsu dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .stall_o       (stall),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_addr_o   (dmem_addr),
        .dmem_be_o     (dmem_be),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_gnt_i    (dmem_gnt),
        .dmem_rvalid_i (dmem_rvalid),
        .dmem_rdata_i  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size in bytes, offset rounded down to a multiple of size.
    function automatic void model(input lsu_op_t op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic [3:0] be, output logic [31:0] wl,
                                  output logic [31:0] rd, output logic err, output logic st);
        int size;
        int off;
        int v;
        logic [31:0] lane;
        st   = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        size = (op == OP_LB || op == OP_LBU || op == OP_SB) ? 1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 4;
        off  = (int'(addr % 4) / size) * size;
        be   = 4'(((1 << size) - 1) << off);
        wl   = (size == 1) ? (wdata & 32'hFF) * 32'h01010101 :
               (size == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
        lane = rdata >> (8 * off);
        case (op)
            OP_LB:   begin v = int'(lane & 32'hFF);   if (v > 127)   v -= 256;   end
            OP_LBU:  v = int'(lane & 32'hFF);
            OP_LH:   begin v = int'(lane & 32'hFFFF); if (v > 32767) v -= 65536; end
            OP_LHU:  v = int'(lane & 32'hFFFF);
            OP_LW:   v = int'(lane);
            default: v = 0;
        endcase
        rd  = 32'(v);
        err = 1'b0;
`ifdef KAMUS_LSU_MISALIGN_TRAP_EN
        if ((addr % size) != 0) begin
            err = 1'b1;
            rd  = 32'd0;
        end
`endif
    endfunction

    task automatic run_op(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gd, input int rvd);
        logic [3:0]  ebe;
        logic [31:0] ewl;
        logic [31:0] erd;
        logic        eerr;
        logic        st;
        model(op, addr, wdata, rdata, ebe, ewl, erd, eerr, st);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_rsp", 32'(rsp_valid), 32'd0);
        chk("rdata_hold", rsp_rdata, last_rdata);
        @(posedge clk);
        if (eerr) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            chk("trap_rsp", 32'(rsp_valid), 32'd1);
            chk("trap_err", 32'(rsp_err), 32'd1);
            chk("trap_rdata", rsp_rdata, 32'd0);
            chk("trap_noreq", 32'(dmem_req), 32'd0);
            last_rdata = 32'd0;
            @(posedge clk);
            return;
        end
        for (int i = 0; i <= gd; i++) begin
            @(negedge clk);
            req_valid   = 1'b0;
            dmem_gnt    = (i == gd);
            dmem_rvalid = !st && (i == gd);
            dmem_rdata  = ~rdata;
            #1;
            chk("req_req", 32'(dmem_req), 32'd1);
            chk("req_we", 32'(dmem_we), 32'(st));
            chk("req_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("req_be", 32'(dmem_be), 32'(ebe));
            if (st) chk("req_wdata", dmem_wdata, ewl);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_rsp", 32'(rsp_valid), 32'd0);
            chk("req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
        end
        if (!st) begin
            for (int j = 0; j <= rvd; j++) begin
                @(negedge clk);
                dmem_gnt    = 1'b0;
                dmem_rvalid = (j == rvd);
                dmem_rdata  = (j == rvd) ? rdata : $urandom;
                #1;
                chk("wait_noreq", 32'(dmem_req), 32'd0);
                chk("wait_stall", 32'(stall), 32'd1);
                chk("wait_rsp", 32'(rsp_valid), 32'd0);
                @(posedge clk);
            end
        end
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        chk("done_rsp", 32'(rsp_valid), 32'd1);
        chk("done_rdata", rsp_rdata, erd);
        chk("done_err", 32'(rsp_err), 32'(eerr));
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_ready", 32'(req_ready), 32'd0);
        last_rdata = erd;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = OP_LB; req_addr = '0; req_wdata = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_dreq", 32'(dmem_req), 32'd0);
        chk("rst_dwe", 32'(dmem_we), 32'd0);
        chk("rst_daddr", dmem_addr, 32'd0);
        chk("rst_dbe", 32'(dmem_be), 32'd0);
        chk("rst_dwdata", dmem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0);
        run_op(OP_LB, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 0);
        run_op(OP_LBU, 32'h0000_2002, 32'h0, 32'h0080_0000, 0, 0);
        run_op(OP_LW, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, 0);
        run_op(OP_LH, 32'h0000_3001, 32'h0, 32'h1234_8765, 0, 1);
        run_op(OP_SH, 32'h0000_3002, 32'h5555_C3A5, 32'h0, 1, 0);
        run_op(OP_SW, 32'h0000_3007, 32'hCAFE_F00D, 32'h0, 0, 0);

        // Reset while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_5004;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        chk("wait_before_rst", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_rdata", rsp_rdata, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("postrst_rsp", 32'(rsp_valid), 32'd0);
        chk("postrst_ready", 32'(req_ready), 32'd1);
        chk("postrst_rdata", rsp_rdata, 32'd0);

        // Request held high across DONE.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h0000_0010; req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dmem_gnt = 1'b0; req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0024;
        #1;
        chk("hold_done_rsp", 32'(rsp_valid), 32'd1);
        chk("hold_done_ready", 32'(req_ready), 32'd0);
        chk("hold_done_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("hold_idle_ready", 32'(req_ready), 32'd1);
        chk("hold_idle_stall", 32'(stall), 32'd1);
        chk("hold_idle_noreq", 32'(dmem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; dmem_gnt = 1'b1;
        #1;
        chk("hold_req", 32'(dmem_req), 32'd1);
        chk("hold_addr", dmem_addr, 32'h0000_0024);
        @(posedge clk);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk("hold_rsp", 32'(rsp_valid), 32'd1);
        chk("hold_rdata", rsp_rdata, 32'h0000_1234);
        last_rdata = 32'h0000_1234;
        @(posedge clk);

        for (int k = 0; k < 40; k++) begin
            run_op(lsu_op_t'(3'($urandom_range(0, 7))), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
